// File: rtl/riscv_alu_pkg.sv
// Shared types and helpers for the RV32 execute-stage ALU.
// Optional RV32I extension ops are enabled by defining RISCV_ALU_RV32I_EXT_EN.
package riscv_alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_t;

  // Extension codes only count as valid when the extension is built in.
  function automatic logic is_valid_op(alu_op_t op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB: return 1'b1;
`ifdef RISCV_ALU_RV32I_EXT_EN
      ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA; only instantiated when
// RISCV_ALU_RV32I_EXT_EN is defined.
module riscv_alu_shifter
  import riscv_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  alu_op_t          op_i,
  output logic [WIDTH-1:0] shifted_o
);

  always_comb begin
    case (op_i)
      ALU_SLL: shifted_o = data_i << shamt_i;
      ALU_SRA: shifted_o = $unsigned($signed(data_i) >>> shamt_i);
      default: shifted_o = data_i >> shamt_i;
    endcase
  end

endmodule

// File: rtl/riscv_alu.sv
// Registered RV32 integer ALU: one-cycle latency, zero and invalid-op flags.
// Define RISCV_ALU_RV32I_EXT_EN to add XOR, shifts, SLT and SLTU.
module riscv_alu
  import riscv_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             inv_op
);

  alu_op_t          op;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             inv_d, inv_q;

  assign op = alu_op_t'(alu_op);

`ifdef RISCV_ALU_RV32I_EXT_EN
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH-1:0] shift_res;

  riscv_alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .data_i   (in_a),
    .shamt_i  (in_b[SHW-1:0]),
    .op_i     (op),
    .shifted_o(shift_res)
  );
`endif

  always_comb begin
    result_d = '0;
    inv_d    = !is_valid_op(op);
    case (op)
      ALU_AND: result_d = in_a & in_b;
      ALU_OR:  result_d = in_a | in_b;
      ALU_ADD: result_d = in_a + in_b;
      ALU_SUB: result_d = in_a - in_b;
`ifdef RISCV_ALU_RV32I_EXT_EN
      ALU_XOR:                   result_d = in_a ^ in_b;
      ALU_SLL, ALU_SRL, ALU_SRA: result_d = shift_res;
      ALU_SLT:  result_d[0] = $signed(in_a) < $signed(in_b);
      ALU_SLTU: result_d[0] = in_a < in_b;
`endif
      default: result_d = '0;
    endcase
    // zero is derived from the exact value being registered so they never disagree
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      inv_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      inv_q    <= inv_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign inv_op = inv_q;

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: directed vectors plus randomized
// back-to-back traffic against a behavioural model.
module tb_riscv_alu;

  localparam int W = 32;

`ifdef RISCV_ALU_RV32I_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  typedef struct packed {
    logic        inv;
    logic        zero;
    logic [31:0] res;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        i;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   alu_op;
  logic [W-1:0] in_a, in_b, result;
  logic         zero, inv_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .alu_op(alu_op),
    .in_a  (in_a),
    .in_b  (in_b),
    .result(result),
    .zero  (zero),
    .inv_op(inv_op)
  );

  // Behavioural reference: arithmetic straight from the operation table.
  function automatic exp_t ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    exp_t        e;
    int unsigned sh;
    longint      sa, sb;
    sh    = b % 32;
    sa    = longint'(int'(a));
    sb    = longint'(int'(b));
    e.inv = 1'b0;
    e.res = 32'd0;
    case (op)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: e.res = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'd6: e.res = 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
      4'd3: if (EXT) e.res = a ^ b; else e.inv = 1'b1;
      4'd4: if (EXT) e.res = 32'(64'(a) * (64'd1 << sh)); else e.inv = 1'b1;
      4'd5: if (EXT) e.res = a / (32'd1 << sh); else e.inv = 1'b1;
      4'd7: if (EXT) e.res = 32'(sa >>> sh); else e.inv = 1'b1;
      4'd8: if (EXT) e.res = (sa < sb) ? 32'd1 : 32'd0; else e.inv = 1'b1;
      4'd9: if (EXT) e.res = (a < b) ? 32'd1 : 32'd0; else e.inv = 1'b1;
      default: e.inv = 1'b1;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic drive(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    alu_op = op;
    in_a   = a;
    in_b   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    alu_op = 4'b0010;
    in_a   = 32'hFFFF_FFFF;
    in_b   = 32'd1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (result !== 32'd0 || zero !== 1'b1 || inv_op !== 1'b0) begin
        errors++;
        $display("FAIL reset cycle %0d: got result=%h zero=%b inv_op=%b, want 00000000/1/0",
                 c, result, zero, inv_op);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'd0 || zero !== 1'b1 || inv_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_add_wrap: got result=%h zero=%b inv_op=%b, want 00000000/1/0",
               result, zero, inv_op);
    end
  endtask

  task automatic test_logic();
    vec_t tv[2] = '{
      '{4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0},
      '{4'b0001, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0}};
    for (int k = 0; k < 2; k++) begin
      drive(tv[k].op, tv[k].a, tv[k].b);
      checks++;
      if (result !== tv[k].r || zero !== tv[k].z || inv_op !== tv[k].i) begin
        errors++;
        $display("FAIL logic[%0d] op=%b: got %h/%b/%b, want %h/%b/%b", k, tv[k].op,
                 result, zero, inv_op, tv[k].r, tv[k].z, tv[k].i);
      end
    end
  endtask

  task automatic test_add();
    vec_t tv[2] = '{
      '{4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0},
      '{4'b0010, 32'h5,         32'hFFFF_FFFB, 32'h0,         1'b1, 1'b0}};
    for (int k = 0; k < 2; k++) begin
      drive(tv[k].op, tv[k].a, tv[k].b);
      checks++;
      if (result !== tv[k].r || zero !== tv[k].z || inv_op !== tv[k].i) begin
        errors++;
        $display("FAIL add[%0d]: got %h/%b/%b, want %h/%b/%b", k,
                 result, zero, inv_op, tv[k].r, tv[k].z, tv[k].i);
      end
    end
  endtask

  task automatic test_sub();
    vec_t tv[2] = '{
      '{4'b0110, 32'h3,         32'h5,         32'hFFFF_FFFE, 1'b0, 1'b0},
      '{4'b0110, 32'h1234_5678, 32'h1234_5678, 32'h0,         1'b1, 1'b0}};
    for (int k = 0; k < 2; k++) begin
      drive(tv[k].op, tv[k].a, tv[k].b);
      checks++;
      if (result !== tv[k].r || zero !== tv[k].z || inv_op !== tv[k].i) begin
        errors++;
        $display("FAIL sub[%0d]: got %h/%b/%b, want %h/%b/%b", k,
                 result, zero, inv_op, tv[k].r, tv[k].z, tv[k].i);
      end
    end
  endtask

  task automatic test_invalid();
    vec_t tv[4] = '{
      '{4'b1111, 32'hDEAD_BEEF, 32'h1, 32'h0, 1'b1, 1'b1},
      '{4'b1100, 32'hDEAD_BEEF, 32'h1, 32'h0, 1'b1, 1'b1},
      '{4'b1010, 32'hDEAD_BEEF, 32'h1, 32'h0, 1'b1, 1'b1},
      '{4'b0000, 32'hDEAD_BEEF, 32'h1, 32'h1, 1'b0, 1'b0}};
    for (int k = 0; k < 4; k++) begin
      drive(tv[k].op, tv[k].a, tv[k].b);
      checks++;
      if (result !== tv[k].r || zero !== tv[k].z || inv_op !== tv[k].i) begin
        errors++;
        $display("FAIL invalid[%0d] op=%b: got %h/%b/%b, want %h/%b/%b", k, tv[k].op,
                 result, zero, inv_op, tv[k].r, tv[k].z, tv[k].i);
      end
    end
  endtask

  task automatic test_ext();
`ifdef RISCV_ALU_RV32I_EXT_EN
    vec_t tv[3] = '{
      '{4'b0111, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 1'b0},
      '{4'b1000, 32'hFFFF_FFFF, 32'h1,  32'h1,         1'b0, 1'b0},
      '{4'b1001, 32'hFFFF_FFFF, 32'h1,  32'h0,         1'b1, 1'b0}};
`else
    vec_t tv[3] = '{
      '{4'b0111, 32'h8000_0000, 32'h21, 32'h0, 1'b1, 1'b1},
      '{4'b1000, 32'hFFFF_FFFF, 32'h1,  32'h0, 1'b1, 1'b1},
      '{4'b1001, 32'hFFFF_FFFF, 32'h1,  32'h0, 1'b1, 1'b1}};
`endif
    for (int k = 0; k < 3; k++) begin
      drive(tv[k].op, tv[k].a, tv[k].b);
      checks++;
      if (result !== tv[k].r || zero !== tv[k].z || inv_op !== tv[k].i) begin
        errors++;
        $display("FAIL ext[%0d] op=%b: got %h/%b/%b, want %h/%b/%b", k, tv[k].op,
                 result, zero, inv_op, tv[k].r, tv[k].z, tv[k].i);
      end
    end
  endtask

  // New operation every cycle; outputs checked mid-cycle to confirm they hold.
  task automatic test_back_to_back();
    exp_t exp_q;
    bit   have = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (have) begin
        checks++;
        if ({inv_op, zero, result} !== exp_q) begin
          errors++;
          $display("FAIL b2b[%0d] op=%b: got %h/%b/%b, want %h/%b/%b", n, alu_op,
                   result, zero, inv_op, exp_q.res, exp_q.zero, exp_q.inv);
        end
      end
      alu_op = 4'($urandom_range(0, 15));
      in_a   = $urandom;
      in_b   = $urandom;
      if (n % 4 == 0) in_b = $urandom_range(0, 40);
      if (n % 7 == 0) in_b = in_a;
      if (n % 11 == 0) in_a = 32'h8000_0000 | $urandom_range(0, 3);
      exp_q = ref_alu(alu_op, in_a, in_b);
      have  = 1'b1;
    end
    @(posedge clk);
    #1;
    checks++;
    if ({inv_op, zero, result} !== exp_q) begin
      errors++;
      $display("FAIL b2b_last: got %h/%b/%b, want %h/%b/%b",
               result, zero, inv_op, exp_q.res, exp_q.zero, exp_q.inv);
    end
  endtask

  task automatic test_midstream_reset();
    exp_t e;
    drive(4'b0010, 32'h1, 32'h1);
    @(negedge clk);
    rst    = 1'b1;
    alu_op = 4'b1111;
    in_a   = 32'hAAAA_5555;
    in_b   = 32'h1;
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'd0 || zero !== 1'b1 || inv_op !== 1'b0) begin
      errors++;
      $display("FAIL midstream_reset: got %h/%b/%b, want 00000000/1/0", result, zero, inv_op);
    end
    @(negedge clk);
    rst    = 1'b0;
    alu_op = 4'b0001;
    in_a   = 32'h1234_0000;
    in_b   = 32'h0000_5678;
    e      = ref_alu(alu_op, in_a, in_b);
    @(posedge clk);
    #1;
    checks++;
    if ({inv_op, zero, result} !== e) begin
      errors++;
      $display("FAIL post_reset_first_op: got %h/%b/%b, want %h/%b/%b",
               result, zero, inv_op, e.res, e.zero, e.inv);
    end
  endtask

  initial begin
    test_reset();
    test_logic();
    test_add();
    test_sub();
    test_invalid();
    test_ext();
    test_back_to_back();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
